// File: rtl/sega_sprite_pixel_shifter.sv
// Sprite ROM word serializer.
// Takes the 16-bit 4bpp words that the upstream index counter addresses and emits
// one pixel per pixel-clock enable, together with its line-buffer X position.
// It handles horizontal flip, transparent pixels (nibble 0) and the end-of-sprite
// marker (nibble F). It also returns a count-enable pulse that advances the
// upstream address counter after each word it takes.
module sega_sprite_pixel_shifter (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_CLK5MNCEN,
    input  logic        i_START,
    input  logic        i_VEN_n,
    input  logic [8:0]  i_XSTART,
    input  logic [3:0]  i_PALBANK,
    input  logic        i_SWAP,
    input  logic [15:0] i_ROM_D,
    input  logic        i_ROM_VALID,
    output logic        o_ROM_REQ,
    output logic        o_CWEN,
    output logic [7:0]  o_PIX,
    output logic [8:0]  o_PIX_X,
    output logic        o_PIX_WE,
    output logic        o_BUSY,
    output logic        o_DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A sprite line that never shows an end marker is cut off after this many words.
    localparam logic [6:0] MAX_WORDS = 7'd64;

    state_t      state, state_nxt;
    logic [8:0]  xcnt, xcnt_nxt;
    logic [3:0]  palbank, palbank_nxt;
    logic [6:0]  wcnt, wcnt_nxt;
    logic [1:0]  nidx, nidx_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic        swap, swap_nxt;
    logic [7:0]  pix_nxt;
    logic [8:0]  pix_x_nxt;
    logic        pix_we_nxt, cwen_nxt, done_nxt;
    logic        load;
    logic [1:0]  sel;
    logic [3:0]  cur_nib;

    // Select the current nibble. Flip walks the word from the low nibble upward.
    always_comb begin
        sel     = swap ? nidx : ~nidx;
        cur_nib = shreg[{sel, 2'b00} +: 4];
    end

    // Request a word while fetching, and during the last nibble of a word so the
    // next word can be prefetched without a gap.
    assign o_ROM_REQ = (state == FETCH) ||
                       ((state == SHIFT) && (nidx == 2'd3) && (cur_nib != 4'hF));

    // Busy stays high through the cycle in which the done pulse is visible.
    assign o_BUSY = (state != IDLE) || o_DONE;

    // Next-state and next-output logic for one pixel-clock step.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can leave one unassigned and infer a latch.
        state_nxt   = state;
        xcnt_nxt    = xcnt;
        palbank_nxt = palbank;
        wcnt_nxt    = wcnt;
        nidx_nxt    = nidx;
        shreg_nxt   = shreg;
        swap_nxt    = swap;
        pix_nxt     = o_PIX;
        pix_x_nxt   = o_PIX_X;
        pix_we_nxt  = 1'b0;
        cwen_nxt    = 1'b0;
        done_nxt    = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (i_START && !i_VEN_n) begin
                    xcnt_nxt    = i_XSTART;
                    palbank_nxt = i_PALBANK;
                    wcnt_nxt    = 7'd0;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                if (i_ROM_VALID) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cur_nib == 4'hF) begin
                    state_nxt = DONE;
                end else begin
                    pix_nxt    = {palbank, cur_nib};
                    pix_x_nxt  = xcnt;
                    pix_we_nxt = (cur_nib != 4'h0);
                    xcnt_nxt   = xcnt + 9'd1;
                    if (nidx != 2'd3) begin
                        nidx_nxt = nidx + 2'd1;
                    end else if (wcnt == MAX_WORDS) begin
                        state_nxt = DONE;
                    end else if (i_ROM_VALID) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A word taken from the ROM restarts the nibble walk and pings the counter.
        if (load) begin
            shreg_nxt = i_ROM_D;
            swap_nxt  = i_SWAP;
            nidx_nxt  = 2'd0;
            wcnt_nxt  = wcnt + 7'd1;
            cwen_nxt  = 1'b1;
        end
    end

    // State and output registers: reset wins on every edge, otherwise advance on CE.
    always_ff @(posedge i_MCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_RST) begin
            state    <= IDLE;
            xcnt     <= 9'd0;
            palbank  <= 4'd0;
            wcnt     <= 7'd0;
            nidx     <= 2'd0;
            shreg    <= 16'd0;
            swap     <= 1'b0;
            o_PIX    <= 8'd0;
            o_PIX_X  <= 9'd0;
            o_PIX_WE <= 1'b0;
            o_CWEN   <= 1'b0;
            o_DONE   <= 1'b0;
        end else if (i_CLK5MNCEN) begin
            state    <= state_nxt;
            xcnt     <= xcnt_nxt;
            palbank  <= palbank_nxt;
            wcnt     <= wcnt_nxt;
            nidx     <= nidx_nxt;
            shreg    <= shreg_nxt;
            swap     <= swap_nxt;
            o_PIX    <= pix_nxt;
            o_PIX_X  <= pix_x_nxt;
            o_PIX_WE <= pix_we_nxt;
            o_CWEN   <= cwen_nxt;
            o_DONE   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sega_sprite_pixel_shifter.sv
// Bench for sega_sprite_pixel_shifter. Expected pixel writes are derived from the
// ROM words by a small reference model and queued before each line is drawn;
// every write the DUT makes pops and compares one entry.
module tb_sega_sprite_pixel_shifter;

    logic        clk = 1'b0;
    logic        rst, ce, start, ven_n, swap, valid;
    logic [8:0]  xstart;
    logic [3:0]  palbank;
    logic [15:0] rom_d;
    logic        rom_req, cwen, pix_we, busy, done;
    logic [7:0]  pix;
    logic [8:0]  pix_x;

    sega_sprite_pixel_shifter dut (
        .i_MCLK      (clk),
        .i_RST       (rst),
        .i_CLK5MNCEN (ce),
        .i_START     (start),
        .i_VEN_n     (ven_n),
        .i_XSTART    (xstart),
        .i_PALBANK   (palbank),
        .i_SWAP      (swap),
        .i_ROM_D     (rom_d),
        .i_ROM_VALID (valid),
        .o_ROM_REQ   (rom_req),
        .o_CWEN      (cwen),
        .o_PIX       (pix),
        .o_PIX_X     (pix_x),
        .o_PIX_WE    (pix_we),
        .o_BUSY      (busy),
        .o_DONE      (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          step_no = 0;
    logic [15:0] words [64];
    logic [16:0] exp_q [$];

    int g_first_wr, g_last_wr, g_first_cwen, g_done_step, g_wr_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One pixel-clock step: a CE edge followed by an idle MCLK edge; outputs are
    // sampled on the falling edge after the idle edge, so CE gating is exercised.
    task automatic step();
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step_no++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix"},    {24'd0, pix},    32'd0);
        check({tag, "_pix_x"},  {23'd0, pix_x},  32'd0);
        check({tag, "_we"},     {31'd0, pix_we}, 32'd0);
        check({tag, "_cwen"},   {31'd0, cwen},   32'd0);
        check({tag, "_busy"},   {31'd0, busy},   32'd0);
        check({tag, "_done"},   {31'd0, done},   32'd0);
        check({tag, "_romreq"}, {31'd0, rom_req}, 32'd0);
    endtask

    // Draw one sprite line from words[]; stall_word >= 0 withholds VALID for three
    // requested cycles once that many words have been taken.
    task automatic run_line(input string name, input logic [8:0] xs, input logic [3:0] pb,
                            input logic sw, input int stall_word, input int budget);
        logic [8:0] x;
        logic [3:0] n;
        logic       ended, req_pre, done_seen;
        int         exp_words, exp_pix, widx, cwen_cnt, stall_left;

        // Reference model: expected writes and word count for this line.
        x = xs; ended = 1'b0; exp_words = 0; exp_pix = 0;
        exp_q.delete();
        for (int w = 0; w < 64 && !ended; w++) begin
            exp_words++;
            for (int i = 0; i < 4 && !ended; i++) begin
                n = sw ? words[w][4*i +: 4] : words[w][(12 - 4*i) +: 4];
                if (n == 4'hF) begin
                    ended = 1'b1;
                end else begin
                    if (n != 4'h0) begin
                        exp_q.push_back({pb, n, x});
                        exp_pix++;
                    end
                    x = x + 9'd1;
                end
            end
        end

        start = 1'b1; ven_n = 1'b0; xstart = xs; palbank = pb; swap = sw; valid = 1'b0;
        step();
        check({name, "_req_after_start"},  {31'd0, rom_req}, 32'd1);
        check({name, "_busy_after_start"}, {31'd0, busy},    32'd1);
        start = 1'b0; ven_n = 1'b1;

        widx = 0; cwen_cnt = 0; done_seen = 1'b0;
        stall_left = (stall_word >= 0) ? 3 : 0;
        g_first_wr = -1; g_last_wr = -1; g_first_cwen = -1; g_done_step = -1; g_wr_cnt = 0;

        for (int c = 0; c < budget && !done_seen; c++) begin
            rom_d   = words[widx];
            valid   = !((widx == stall_word) && (stall_left > 0));
            req_pre = rom_req;
            step();
            if (req_pre && !valid && stall_left > 0) begin
                stall_left--;
                if (stall_left < 2) begin
                    check({name, "_stall_we"},  {31'd0, pix_we},  32'd0);
                    check({name, "_stall_req"}, {31'd0, rom_req}, 32'd1);
                end
            end
            if (pix_we) begin
                g_wr_cnt++;
                if (g_first_wr < 0) g_first_wr = step_no;
                g_last_wr = step_no;
                if (exp_q.size() == 0) begin
                    check({name, "_extra_write"}, {31'd0, pix_we}, 32'd0);
                end else begin
                    check({name, "_pix"}, {15'd0, pix, pix_x}, {15'd0, exp_q.pop_front()});
                end
            end
            if (cwen) begin
                cwen_cnt++;
                if (g_first_cwen < 0) g_first_cwen = step_no;
                if (widx < 63) widx++;
            end
            if (done) begin
                done_seen   = 1'b1;
                g_done_step = step_no;
                check({name, "_busy_with_done"}, {31'd0, busy}, 32'd1);
            end
        end

        check({name, "_done_seen"},  {31'd0, done_seen}, 32'd1);
        check({name, "_write_cnt"},  g_wr_cnt,           exp_pix);
        check({name, "_cwen_cnt"},   cwen_cnt,           exp_words);
        check({name, "_queue_left"}, exp_q.size(),       32'd0);

        valid = 1'b0;
        step();
        check({name, "_done_cleared"}, {31'd0, done}, 32'd0);
        check({name, "_busy_cleared"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_cnt;

        rst = 1'b1; ce = 1'b0; start = 1'b0; ven_n = 1'b1; swap = 1'b0; valid = 1'b0;
        xstart = 9'd0; palbank = 4'd0; rom_d = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // START while the comparator reports the line out of range.
        start = 1'b1; ven_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ven_high_busy", {31'd0, busy},    32'd0);
            check("ven_high_req",  {31'd0, rom_req}, 32'd0);
        end
        start = 1'b0;

        // Plain two-word line, VALID always high.
        foreach (words[i]) words[i] = 16'h0000;
        words[0] = 16'h1234; words[1] = 16'h5F00;
        run_line("basic", 9'h010, 4'h3, 1'b0, -1, 40);
        check("basic_first_pix_latency", g_first_wr - g_first_cwen, 32'd1);
        check("basic_no_gap", g_last_wr - g_first_wr, g_wr_cnt - 1);

        // Flipped word puts the end marker first.
        foreach (words[i]) words[i] = 16'h0000;
        words[0] = 16'h0A0F;
        run_line("swap_end", 9'h010, 4'h3, 1'b1, -1, 40);

        // X counter wraps from 511 to 0.
        foreach (words[i]) words[i] = 16'h0000;
        words[0] = 16'h1111; words[1] = 16'hFFFF;
        run_line("x_wrap", 9'h1FE, 4'hA, 1'b0, -1, 40);

        // VALID withheld after the first word; transparent nibbles skip writes.
        foreach (words[i]) words[i] = 16'h0000;
        words[0] = 16'h1020; words[1] = 16'h0304; words[2] = 16'hF000;
        run_line("stall", 9'h040, 4'h5, 1'b0, 1, 60);

        // 64 words without an end marker hit the runaway guard.
        foreach (words[i]) words[i] = {4'h9, 4'(i % 15), 4'h0, 4'h6};
        run_line("runaway", 9'h180, 4'hC, 1'b0, -1, 400);
        check("runaway_done_after_last", g_done_step - g_last_wr, 32'd1);

        // Reset in the middle of a line, with CE low on the reset edge.
        foreach (words[i]) words[i] = 16'h1111;
        start = 1'b1; ven_n = 1'b0; xstart = 9'h020; palbank = 4'h7; swap = 1'b0;
        step();
        start = 1'b0; ven_n = 1'b1; valid = 1'b1; rom_d = 16'h1111;
        repeat (4) step();
        check("midline_pix_before_rst", {24'd0, pix}, 32'h71);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midline_rst");
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("midline_no_done", done_cnt, 32'd0);
        check("midline_idle_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
